// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter giving two requesters shared access to one data memory
// Ports: clk, rst_n (async active-low); per requester req/we/addr/wdata in and gnt/rvalid/rdata out;
//        err flags an out-of-range address; mem_addr/mem_data_in/mem_we drive the memory,
//        mem_data_out returns its registered read data.
module data_mem_arbiter #(
  parameter int SIZE     = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [SIZE-1:0] addr0,
  input  logic [SIZE-1:0] addr1,
  input  logic [SIZE-1:0] wdata0,
  input  logic [SIZE-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [SIZE-1:0] rdata0,
  output logic [SIZE-1:0] rdata1,
  output logic            err,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_data_in,
  output logic            mem_we,
  input  logic [SIZE-1:0] mem_data_out
);
  // one extra bit so the limit itself is representable when MEM_SIZE == 2**SIZE
  localparam logic [SIZE:0] LIMIT = (SIZE+1)'(MEM_SIZE);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t          r_state, w_next;
  logic            r_last, r_sel, r_we, r_err;
  logic            w_pick1, w_take, w_we, w_oor, w_resp;
  logic [SIZE-1:0] w_addr, w_wdata;
  // r_last = 1 means requester 1 was served last, so requester 0 wins a tie
  assign w_pick1 = req1 & (~req0 | ~r_last);
  assign w_take  = (r_state == IDLE) & (req0 | req1);
  assign w_we    = w_pick1 ? we1 : we0;
  assign w_addr  = w_pick1 ? addr1 : addr0;
  assign w_wdata = w_pick1 ? wdata1 : wdata0;
  assign w_oor   = {1'b0, w_addr} >= LIMIT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE  ? (w_take ? ISSUE : IDLE) :
             r_state == ISSUE ? (r_we ? IDLE : RESP) : IDLE;
  end
  // the transaction is captured only on the IDLE sampling edge; later request changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_sel       <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else if (w_take) begin
      r_last      <= w_pick1;
      r_sel       <= w_pick1;
      r_we        <= w_we;
      r_err       <= w_oor;
      mem_we      <= w_we & ~w_oor;
      mem_addr    <= w_addr;
      mem_data_in <= w_wdata;
    end else begin
      mem_we      <= 1'b0;
    end
  end
  always_comb begin
    w_resp  = r_state == RESP;
    gnt0    = (r_state == ISSUE) & ~r_sel;
    gnt1    = (r_state == ISSUE) & r_sel;
    err     = (r_state == ISSUE) & r_err;
    rvalid0 = w_resp & ~r_sel;
    rvalid1 = w_resp & r_sel;
    rdata0  = (w_resp & ~r_sel & ~r_err) ? mem_data_out : '0;
    rdata1  = (w_resp & r_sel & ~r_err) ? mem_data_out : '0;
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: vector table, directed corner sequences and randomized traffic against a transaction model
module tb_data_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic [31:0] mem [1024] = '{default: '0};
  int          n_vec = 0, n_err = 0;

  data_mem_arbiter #(.SIZE(32), .MEM_SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err(err), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_data_in;
    mem_data_out <= (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : '0;
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd, input string nm);
    int n = 0;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    do begin @(negedge clk); n++; end while (!(gnt0 | gnt1) && n < 8);
    chk({nm, " latency"}, 32'(n), 32'd1);
    chk({nm, " gnt"}, 32'({gnt1, gnt0}), p ? 32'd2 : 32'd1);
    chk({nm, " err"}, 32'(err), 32'(e_err));
    chk({nm, " mem_we"}, 32'(mem_we), 32'(we & ~e_err));
    if (!e_err) chk({nm, " mem_addr"}, mem_addr, a);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    if (!we) begin
      chk({nm, " rvalid"}, 32'({rvalid1, rvalid0}), p ? 32'd2 : 32'd1);
      chk({nm, " rdata"}, p ? rdata1 : rdata0, e_rd);
      chk({nm, " other rdata"}, p ? rdata0 : rdata1, 32'd0);
      @(negedge clk);
    end else begin
      chk({nm, " rvalid"}, 32'({rvalid1, rvalid0}), 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 32'd1024 + 32'($urandom_range(0, 5));
      1:       return 32'hFFFF_FFFF;
      default: return 32'd16 + 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int          k, prev;
    int          gq [$];
    int          gc [$];
    int          rem, len;
    logic        m_last, m_port, m_we, m_oor, pend0, pend1, eg, ev;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [31:0] mm [16];
    tbl[0]  = '{1'b0, 1'b1, 32'd5,          32'h1234, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'd5,          32'd0,    1'b0, 32'h1234};
    tbl[2]  = '{1'b1, 1'b1, 32'd1024,       32'd7,    1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b0, 32'd1024,       32'd0,    1'b1, 32'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'd1023,       32'hA5A5, 1'b0, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 32'd1023,       32'd0,    1'b0, 32'hA5A5};
    tbl[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'h55,   1'b1, 32'd0};
    tbl[7]  = '{1'b1, 1'b0, 32'd7,          32'd0,    1'b0, 32'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'd5,          32'hBEEF, 1'b0, 32'd0};
    tbl[9]  = '{1'b1, 1'b0, 32'd5,          32'd0,    1'b0, 32'hBEEF};
    tbl[10] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd0,    1'b1, 32'd0};

    #12;
    chk("reset gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("reset rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_data_in", mem_data_in, 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    chk("reset rdata1", rdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata,
          $sformatf("vec%0d", i));

    // contention: both reads held from reset
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1023;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("contend both gnt", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0 | gnt1) begin gq.push_back(gnt1 ? 1 : 0); gc.push_back(c); end
      if (rvalid0 | rvalid1) begin
        chk("contend rvalid port", 32'(rvalid1), gq.size() > 0 ? 32'(gq[$]) : 32'd9);
        chk("contend rvalid delay", 32'(c), gc.size() > 0 ? 32'(gc[$] + 1) : 32'd0);
        chk("contend rdata", rvalid1 ? rdata1 : rdata0, rvalid1 ? 32'hA5A5 : 32'hBEEF);
      end
      if (c == 12) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("contend grants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      chk($sformatf("contend order %0d", i), 32'(gq[i]), 32'(i % 2));
      chk($sformatf("contend cycle %0d", i), 32'(gc[i]), 32'(1 + 3 * i));
    end
    repeat (2) @(negedge clk);

    // back-to-back writes on port 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd0; wdata1 = 32'h100;
    k = 0; prev = 0;
    for (int c = 1; c <= 12 && k < 4; c++) begin
      @(negedge clk);
      chk("b2b no gnt0", 32'(gnt0), 32'd0);
      if (gnt1) begin
        chk("b2b gap", 32'(c - prev), k == 0 ? 32'd1 : 32'd2);
        chk("b2b mem_addr", mem_addr, 32'(k));
        chk("b2b mem_we", 32'(mem_we), 32'd1);
        prev = c; k++;
        addr1 = 32'(k); wdata1 = 32'h100 + 32'(k);
        if (k == 4) req1 = 1'b0;
      end
    end
    chk("b2b count", 32'(k), 32'd4);
    repeat (2) @(negedge clk);
    txn(1'b0, 1'b0, 32'd2, 32'd0, 1'b0, 32'h102, "b2b readback");

    // reset during ISSUE of a write: it must not be committed
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hDEAD;
    @(posedge clk); #1;
    chk("abort mem_we before", 32'(mem_we), 32'd1);
    rst_n = 1'b0; req0 = 1'b0;
    #1;
    chk("abort gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("abort mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b0, 32'd9, 32'd0, 1'b0, 32'd0, "abort readback");

    // reset during RESP of a read
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    @(negedge clk);
    chk("midread gnt", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("midread rvalid before", 32'(rvalid0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midread rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    chk("midread rdata0", rdata0, 32'd0);
    chk("midread misc", 32'({gnt1, gnt0, err, mem_we}), 32'd0);
    chk("midread mem_addr", mem_addr, 32'd0);
    chk("midread mem_data_in", mem_data_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midread idle", 32'({gnt1, gnt0, mem_we}), 32'd0);
    end

    // randomized traffic against a transaction-level model
    foreach (mm[i]) mm[i] = '0;
    rem = 0; len = 0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0; m_oor = 1'b0;
    m_addr = '0; m_wdata = '0; m_rd = '0; pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rem > 0) rem--;
      eg = rem > 0 && rem == len - 1;
      ev = rem == 1 && !m_we;
      chk("rnd gnt", 32'({gnt1, gnt0}), eg ? (m_port ? 32'd2 : 32'd1) : 32'd0);
      chk("rnd rvalid", 32'({rvalid1, rvalid0}), ev ? (m_port ? 32'd2 : 32'd1) : 32'd0);
      chk("rnd err", 32'(err), 32'(eg && m_oor));
      chk("rnd mem_we", 32'(mem_we), 32'(eg && m_we && !m_oor));
      chk("rnd rdata0", rdata0, (ev && !m_port) ? m_rd : 32'd0);
      chk("rnd rdata1", rdata1, (ev && m_port) ? m_rd : 32'd0);
      if (eg) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        if (m_port) begin req1 = 1'b0; pend1 = 1'b0; end
        else        begin req0 = 1'b0; pend0 = 1'b0; end
        if (m_we && !m_oor) mm[m_addr[3:0]] = m_wdata;
      end
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = rnd_addr(); wdata0 = $urandom();
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = rnd_addr(); wdata1 = $urandom();
      end
      if (rem == 0 && (req0 || req1)) begin
        m_port  = req1 && (!req0 || !m_last);
        m_last  = m_port;
        m_we    = m_port ? we1 : we0;
        m_addr  = m_port ? addr1 : addr0;
        m_wdata = m_port ? wdata1 : wdata0;
        m_oor   = m_addr >= 32'd1024;
        m_rd    = m_oor ? 32'd0 : mm[m_addr[3:0]];
        len     = m_we ? 2 : 3;
        rem     = len;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
